// File: rtl/gsu_rf_pkg.sv
// Shared definitions for the GSU general-register file: default special
// register indices, PC update source priority and the byte-lane merge helper.
package gsu_rf_pkg;

   localparam int unsigned RF_PC_IDX       = 15;
   localparam int unsigned RF_LOOP_CNT_IDX = 12;
   localparam int unsigned RF_LOOP_TGT_IDX = 13;

   // Widest register the lane-merge helper handles; callers zero-extend.
   localparam int unsigned MERGE_MAX_W     = 64;

   // PC update sources, highest priority first.
   typedef enum logic [2:0] {
      WR_EXPLICIT,
      WR_CCHLD,
      WR_LOOP,
      WR_PCINC,
      WR_HOLD
   } wr_src_e;

   // Replace the low and/or high half of old_val with new_val; half_w is
   // the lane width in bits.
   function automatic logic [MERGE_MAX_W-1:0] lane_merge(
      input logic [MERGE_MAX_W-1:0] old_val,
      input logic [MERGE_MAX_W-1:0] new_val,
      input logic                   lo,
      input logic                   hi,
      input int unsigned            half_w
   );
      logic [MERGE_MAX_W-1:0] res;
      res = old_val;
      for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
         if ((lo && (i < half_w)) || (hi && (i >= half_w) && (i < 2 * half_w))) begin
            res[i] = new_val[i];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/gsu_rf_selreg.sv
// Source/destination latches (FROM/TO/WITH prefixes) and the X-read and
// write address muxes of the GSU register file.
module gsu_rf_selreg #(
   parameter int unsigned SEL_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEL_W-1:0] instr,
   input  logic             to,
   input  logic             from,
   input  logic             with_pfx,
   input  logic             resflags,
   input  logic             ssel,
   input  logic             dsel,
   output logic [SEL_W-1:0] sreg,
   output logic [SEL_W-1:0] dreg,
   output logic [SEL_W-1:0] xa,
   output logic [SEL_W-1:0] wa
);

   logic [SEL_W-1:0] sreg_q;
   logic [SEL_W-1:0] dreg_q;
   logic [SEL_W-1:0] sreg_d;
   logic [SEL_W-1:0] dreg_d;

   // Next latch values: a prefix loading a latch beats the end-of-instruction clear.
   always_comb begin
      sreg_d = sreg_q;
      dreg_d = dreg_q;
      if (with_pfx) begin
         sreg_d = instr;
         dreg_d = instr;
      end else if (to || from) begin
         if (to)   dreg_d = instr;
         if (from) sreg_d = instr;
      end else if (resflags) begin
         sreg_d = '0;
         dreg_d = '0;
      end
   end

   // Latch registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sreg_q <= '0;
         dreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
         dreg_q <= dreg_d;
      end
   end

   // Address muxes for the X read port and the write port.
   always_comb begin
      xa = ssel ? instr : sreg_q;
      wa = dsel ? instr : dreg_q;
   end

   assign sreg = sreg_q;
   assign dreg = dreg_q;

endmodule

// File: rtl/gsu_regfile_seq.sv
// GSU general-register file with PC sequencing and hardware LOOP support.
// Optional macro GSU_RF_BYPASS_EN: write-to-read forwarding on x/y.
// The WITH prefix input is named with_pfx because `with` is reserved.
module gsu_regfile_seq
   import gsu_rf_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned NUM_REGS     = 16,
   parameter int unsigned SEL_W        = $clog2(NUM_REGS),
   parameter int unsigned PC_IDX       = RF_PC_IDX,
   parameter int unsigned LOOP_CNT_IDX = RF_LOOP_CNT_IDX,
   parameter int unsigned LOOP_TGT_IDX = RF_LOOP_TGT_IDX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [SEL_W-1:0]  instr,
   input  logic              to,
   input  logic              from,
   input  logic              with_pfx,
   input  logic              resflags,
   input  logic              ssel,
   input  logic              dsel,
   input  logic [SEL_W-1:0]  ha,
   input  logic              wr_lo,
   input  logic              wr_hi,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pcen,
   input  logic              cchld,
   input  logic              loopen,
   output logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y,
   output logic [DATA_W-1:0] pc,
   output logic              loop_taken,
   output logic [SEL_W-1:0]  sreg,
   output logic [SEL_W-1:0]  dreg
);

   localparam logic [SEL_W-1:0] PC_SEL  = SEL_W'(PC_IDX);
   localparam logic [SEL_W-1:0] CNT_SEL = SEL_W'(LOOP_CNT_IDX);
   localparam logic [SEL_W-1:0] TGT_SEL = SEL_W'(LOOP_TGT_IDX);
   localparam int unsigned      HALF_W  = DATA_W / 2;

   logic [DATA_W-1:0] rf      [NUM_REGS];
   logic [DATA_W-1:0] rf_next [NUM_REGS];
   logic              loop_taken_q;

   logic [SEL_W-1:0]  xa;
   logic [SEL_W-1:0]  wa;
   logic              wr_any;
   logic [DATA_W-1:0] merged;
   logic [DATA_W-1:0] cnt_dec;
   logic              branch;
   wr_src_e           pc_src;
   logic [DATA_W-1:0] pc_next;

   gsu_rf_selreg #(
      .SEL_W (SEL_W)
   ) u_selreg (
      .clk      (clk),
      .reset    (reset),
      .instr    (instr),
      .to       (to),
      .from     (from),
      .with_pfx (with_pfx),
      .resflags (resflags),
      .ssel     (ssel),
      .dsel     (dsel),
      .sreg     (sreg),
      .dreg     (dreg),
      .xa       (xa),
      .wa       (wa)
   );

   // Write-port value and LOOP decrement/branch decision from pre-edge contents.
   always_comb begin
      wr_any  = wr_lo || wr_hi;
      merged  = DATA_W'(lane_merge(MERGE_MAX_W'(rf[wa]), MERGE_MAX_W'(wr_data),
                                   wr_lo, wr_hi, HALF_W));
      cnt_dec = rf[CNT_SEL] - DATA_W'(1);
      branch  = loopen && (cnt_dec != '0);
   end

   // PC source selection in priority order, then the selected next value.
   always_comb begin
      pc_src = WR_HOLD;
      if (wr_any && (wa == PC_SEL)) pc_src = WR_EXPLICIT;
      else if (cchld)               pc_src = WR_CCHLD;
      else if (branch)              pc_src = WR_LOOP;
      else if (pcen)                pc_src = WR_PCINC;

      pc_next = rf[PC_SEL];
      case (pc_src)
         WR_EXPLICIT: pc_next = merged;
         WR_CCHLD:    pc_next = wr_data;
         WR_LOOP:     pc_next = rf[TGT_SEL];
         WR_PCINC:    pc_next = rf[PC_SEL] + DATA_W'(1);
         default:     pc_next = rf[PC_SEL];
      endcase
   end

   // Next register array: explicit write, then LOOP decrement unless the
   // counter itself was written, then the PC from the priority chain.
   always_comb begin
      rf_next = rf;
      if (wr_any) rf_next[wa] = merged;
      if (loopen && !(wr_any && (wa == CNT_SEL))) rf_next[CNT_SEL] = cnt_dec;
      rf_next[PC_SEL] = pc_next;
   end

   // Register array and LOOP status, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf           <= '{default: '0};
         loop_taken_q <= 1'b0;
      end else begin
         rf           <= rf_next;
         loop_taken_q <= branch;
      end
   end

`ifdef GSU_RF_BYPASS_EN
   // Read ports forward the write-port value (not the PC sequencing result).
   always_comb begin
      x = (wr_any && (wa == xa)) ? merged : rf[xa];
      y = (wr_any && (wa == ha)) ? merged : rf[ha];
   end
`else
   // Read ports return the registered contents.
   always_comb begin
      x = rf[xa];
      y = rf[ha];
   end
`endif

   assign pc         = rf[PC_SEL];
   assign loop_taken = loop_taken_q;

endmodule

// File: tb/tb_gsu_regfile_seq.sv
module tb_gsu_regfile_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  instr;
   logic        to_i, from_i, with_i, resflags;
   logic        ssel, dsel;
   logic [3:0]  ha;
   logic        wr_lo, wr_hi;
   logic [15:0] wr_data;
   logic        pcen, cchld, loopen;
   logic [15:0] x, y, pc;
   logic        loop_taken;
   logic [3:0]  sreg, dreg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gsu_regfile_seq #(
      .DATA_W   (16),
      .NUM_REGS (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .to         (to_i),
      .from       (from_i),
      .with_pfx   (with_i),
      .resflags   (resflags),
      .ssel       (ssel),
      .dsel       (dsel),
      .ha         (ha),
      .wr_lo      (wr_lo),
      .wr_hi      (wr_hi),
      .wr_data    (wr_data),
      .pcen       (pcen),
      .cchld      (cchld),
      .loopen     (loopen),
      .x          (x),
      .y          (y),
      .pc         (pc),
      .loop_taken (loop_taken),
      .sreg       (sreg),
      .dreg       (dreg)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic clr_strobes();
      to_i = 0; from_i = 0; with_i = 0; resflags = 0;
      wr_lo = 0; wr_hi = 0; pcen = 0; cchld = 0; loopen = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0]  instr;
      logic        wth, to, frm, resf;
      logic        ssel, dsel;
      logic [3:0]  ha;
      logic        lo, hi;
      logic [15:0] data;
      logic        pcen, cchld, loopen;
      logic [15:0] ex, ey, epc;
      logic [3:0]  es, ed;
      logic        elt;
   } vec_t;

   vec_t vec[25];

   // pf: 4=WITH 2=TO 1=FROM 8=RESFLAGS; we: 1=lo 2=hi; op: 1=pcen 2=cchld 4=loopen
   function automatic vec_t mk(input int in, input int pf, input int ss, input int ds,
                               input int h, input int we, input int dat, input int op,
                               input int ex, input int ey, input int epc,
                               input int es, input int ed, input int elt);
      vec_t v;
      v.instr = 4'(in);
      v.wth = pf[2]; v.to = pf[1]; v.frm = pf[0]; v.resf = pf[3];
      v.ssel = ss[0]; v.dsel = ds[0]; v.ha = 4'(h);
      v.lo = we[0]; v.hi = we[1]; v.data = 16'(dat);
      v.pcen = op[0]; v.cchld = op[1]; v.loopen = op[2];
      v.ex = 16'(ex); v.ey = 16'(ey); v.epc = 16'(epc);
      v.es = 4'(es); v.ed = 4'(ed); v.elt = elt[0];
      return v;
   endfunction

   // ---------------- reference model ----------------
   logic [15:0] m_r[16];
   logic [3:0]  m_s, m_d;
   logic        m_lt;

   function automatic logic [15:0] lanes(input logic [15:0] o, input logic [15:0] n,
                                         input logic lo, input logic hi);
      logic [15:0] r;
      r = o;
      if (lo) r[7:0]  = n[7:0];
      if (hi) r[15:8] = n[15:8];
      return r;
   endfunction

   function automatic logic [15:0] m_read(input logic [3:0] a);
      logic [15:0] v;
      logic [3:0]  wa;
      v  = m_r[a];
      wa = dsel ? instr : m_d;
`ifdef GSU_RF_BYPASS_EN
      if ((wr_lo || wr_hi) && a == wa) v = lanes(v, wr_data, wr_lo, wr_hi);
`else
      if (wa == 4'hF && a == 4'hF) v = m_r[15];
`endif
      return v;
   endfunction

   task automatic model_edge();
      logic [15:0] old[16];
      logic [3:0]  wa;
      logic        wrote;
      logic [15:0] dec;
      logic        br;
      old   = m_r;
      wa    = dsel ? instr : m_d;
      wrote = wr_lo || wr_hi;
      if (wrote) m_r[wa] = lanes(old[wa], wr_data, wr_lo, wr_hi);
      dec = old[12] - 16'd1;
      br  = loopen && (dec != 16'd0);
      if (loopen && !(wrote && wa == 4'd12)) m_r[12] = dec;
      if (wrote && wa == 4'd15) begin
         // already written by the explicit port
      end else if (cchld)  m_r[15] = wr_data;
      else if (br)         m_r[15] = old[13];
      else if (pcen)       m_r[15] = old[15] + 16'd1;
      m_lt = br;
      if (with_i) begin
         m_s = instr; m_d = instr;
      end else if (to_i || from_i) begin
         if (to_i)   m_d = instr;
         if (from_i) m_s = instr;
      end else if (resflags) begin
         m_s = 0; m_d = 0;
      end
   endtask

   initial begin
      vec[0]  = mk(5,  4, 0, 0, 0,  0, 0,       0, 0,       0,       0,       5, 5, 0);
      vec[1]  = mk(0,  8, 0, 0, 0,  0, 0,       0, 0,       0,       0,       0, 0, 0);
      vec[2]  = mk(3,  0, 0, 1, 3,  3, 'h1111,  0, 0,       'h1111,  0,       0, 0, 0);
      vec[3]  = mk(3,  0, 0, 1, 3,  1, 'hA5C3,  0, 0,       'h11C3,  0,       0, 0, 0);
      vec[4]  = mk(3,  0, 1, 1, 3,  2, 'hBEEF,  0, 'hBEC3,  'hBEC3,  0,       0, 0, 0);
      vec[5]  = mk(15, 0, 0, 1, 15, 3, 'hFFFF,  0, 0,       'hFFFF,  'hFFFF,  0, 0, 0);
      vec[6]  = mk(15, 0, 0, 0, 15, 0, 0,       1, 0,       0,       0,       0, 0, 0);
      vec[7]  = mk(15, 0, 0, 1, 15, 3, 'hFFFF,  0, 0,       'hFFFF,  'hFFFF,  0, 0, 0);
      vec[8]  = mk(15, 0, 0, 0, 15, 0, 'h0200,  3, 0,       'h0200,  'h0200,  0, 0, 0);
      vec[9]  = mk(12, 0, 0, 1, 12, 3, 3,       0, 0,       3,       'h0200,  0, 0, 0);
      vec[10] = mk(13, 0, 0, 1, 13, 3, 'h0100,  0, 0,       'h0100,  'h0200,  0, 0, 0);
      vec[11] = mk(0,  0, 0, 0, 12, 0, 0,       5, 0,       2,       'h0100,  0, 0, 1);
      vec[12] = mk(0,  0, 0, 0, 12, 0, 0,       5, 0,       1,       'h0100,  0, 0, 1);
      vec[13] = mk(15, 0, 1, 0, 12, 0, 0,       5, 'h0101,  0,       'h0101,  0, 0, 0);
      vec[14] = mk(0,  0, 0, 0, 12, 0, 0,       4, 0,       'hFFFF,  'h0100,  0, 0, 1);
      vec[15] = mk(0,  0, 0, 0, 12, 0, 0,       0, 0,       'hFFFF,  'h0100,  0, 0, 0);
      vec[16] = mk(15, 0, 0, 1, 15, 3, 'h4000,  3, 0,       'h4000,  'h4000,  0, 0, 0);
      vec[17] = mk(12, 0, 0, 1, 12, 3, 5,       4, 0,       5,       'h0100,  0, 0, 1);
      vec[18] = mk(9,  12,0, 0, 0,  0, 0,       0, 0,       0,       'h0100,  9, 9, 0);
      vec[19] = mk(4,  1, 0, 0, 0,  0, 0,       0, 0,       0,       'h0100,  4, 9, 0);
      vec[20] = mk(2,  3, 0, 0, 0,  0, 0,       0, 0,       0,       'h0100,  2, 2, 0);
      vec[21] = mk(7,  2, 0, 0, 0,  0, 0,       0, 0,       0,       'h0100,  2, 7, 0);
      vec[22] = mk(0,  8, 0, 0, 0,  0, 0,       0, 0,       0,       'h0100,  0, 0, 0);
      vec[23] = mk(4,  2, 0, 0, 0,  0, 0,       0, 0,       0,       'h0100,  0, 4, 0);
      vec[24] = mk(4,  8, 1, 0, 4,  3, 'h5A5A,  0, 'h5A5A,  'h5A5A,  'h0100,  0, 0, 0);

      // reset state
      reset = 0; instr = 0; ssel = 0; dsel = 0; ha = 0; wr_data = 0;
      clr_strobes();
      #2;
      chk("rst_pc", pc, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_sreg", {12'd0, sreg}, 0);
      chk("rst_dreg", {12'd0, dreg}, 0);
      chk("rst_lt", {15'd0, loop_taken}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1;
      @(posedge clk); #1;

      // directed table
      for (int i = 0; i < 25; i++) begin
         instr = vec[i].instr; with_i = vec[i].wth; to_i = vec[i].to; from_i = vec[i].frm;
         resflags = vec[i].resf; ssel = vec[i].ssel; dsel = vec[i].dsel; ha = vec[i].ha;
         wr_lo = vec[i].lo; wr_hi = vec[i].hi; wr_data = vec[i].data;
         pcen = vec[i].pcen; cchld = vec[i].cchld; loopen = vec[i].loopen;
         @(posedge clk); #1;
         clr_strobes();
         #1;
         chk($sformatf("vec%0d_x", i), x, vec[i].ex);
         chk($sformatf("vec%0d_y", i), y, vec[i].ey);
         chk($sformatf("vec%0d_pc", i), pc, vec[i].epc);
         chk($sformatf("vec%0d_sreg", i), {12'd0, sreg}, {12'd0, vec[i].es});
         chk($sformatf("vec%0d_dreg", i), {12'd0, dreg}, {12'd0, vec[i].ed});
         chk($sformatf("vec%0d_lt", i), {15'd0, loop_taken}, {15'd0, vec[i].elt});
      end

      // same-cycle visibility of a write on y
      instr = 7; dsel = 1; ha = 7; ssel = 0; wr_lo = 1; wr_hi = 1; wr_data = 16'h1234;
      #2;
`ifdef GSU_RF_BYPASS_EN
      chk("byp_y_same", y, 16'h1234);
`else
      chk("byp_y_same", y, 16'h0000);
`endif
      @(posedge clk); #1;
      clr_strobes();
      #1;
      chk("byp_y_next", y, 16'h1234);

      // reset asserted during a LOOP (R12=5, R13=0x0100)
      instr = 15; ssel = 1; dsel = 0; ha = 12; loopen = 1; pcen = 1;
      #2;
      reset = 0;
      #1;
      chk("rstloop_pc", pc, 0);
      chk("rstloop_x", x, 0);
      chk("rstloop_y", y, 0);
      chk("rstloop_lt", {15'd0, loop_taken}, 0);
      @(posedge clk); #1;
      chk("rstloop_hold_y", y, 0);
      chk("rstloop_hold_pc", pc, 0);
      clr_strobes();
      @(negedge clk) reset = 1;
      @(posedge clk); #1;
      chk("rstloop_after_pc", pc, 0);
      chk("rstloop_after_lt", {15'd0, loop_taken}, 0);

      // randomized phase against the model
      for (int k = 0; k < 16; k++) m_r[k] = 0;
      m_s = 0; m_d = 0; m_lt = 0;
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 5))
            0: instr = 12;
            1: instr = 13;
            2: instr = 15;
            default: instr = 4'($urandom);
         endcase
         with_i = ($urandom_range(0, 9) == 0);
         to_i   = ($urandom_range(0, 9) == 0);
         from_i = ($urandom_range(0, 9) == 0);
         resflags = !(with_i || to_i || from_i) && ($urandom_range(0, 5) == 0);
         ssel  = 1'($urandom);
         dsel  = 1'($urandom);
         ha    = 4'($urandom);
         wr_lo = ($urandom_range(0, 2) == 0);
         wr_hi = ($urandom_range(0, 2) == 0);
         wr_data = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
         pcen   = 1'($urandom);
         cchld  = ($urandom_range(0, 9) == 0);
         loopen = ($urandom_range(0, 3) == 0);
         #3;
         chk("rnd_x", x, m_read(ssel ? instr : m_s));
         chk("rnd_y", y, m_read(ha));
         @(posedge clk);
         model_edge();
         #1;
         chk("rnd_pc", pc, m_r[15]);
         chk("rnd_sreg", {12'd0, sreg}, {12'd0, m_s});
         chk("rnd_dreg", {12'd0, dreg}, {12'd0, m_d});
         chk("rnd_lt", {15'd0, loop_taken}, {15'd0, m_lt});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gsu_regfile_seq.md
Name: gsu_regfile_seq

Overview:
Parametrised general-register file for the GSU datapath. It follows on from the fixed 16x16 select/readout block.
- Owns the FROM/TO/WITH source and destination latches, two read ports (X, Y) and one byte-laned write port.
- Has built-in program-counter sequencing on the PC register and hardware LOOP handling on the counter/target registers.
- Sits between instruction decode and the ALU; the fetch unit takes the PC from `pc`.

Parameters:
- DATA_W, 16, register width in bits; must be even (two byte lanes).
- NUM_REGS, 16, number of registers; power of 2, minimum 16.
- SEL_W, $clog2(NUM_REGS), register-select width.
- PC_IDX, 15, index of the program-counter register.
- LOOP_CNT_IDX, 12, index of the loop-counter register.
- LOOP_TGT_IDX, 13, index of the loop-target register.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- instr  input  SEL_W  register field of the current opcode.
- to  input  1  TO prefix: dreg <= instr.
- from  input  1  FROM prefix: sreg <= instr.
- with  input  1  WITH prefix: sreg <= instr and dreg <= instr.
- resflags  input  1  end of instruction: sreg and dreg return to 0.
- ssel  input  1  X read address: 1 = instr, 0 = sreg.
- dsel  input  1  write address: 1 = instr, 0 = dreg.
- ha  input  SEL_W  Y read address.
- wr_lo  input  1  write the low byte lane.
- wr_hi  input  1  write the high byte lane.
- wr_data  input  DATA_W  write data.
- pcen  input  1  increment the PC.
- cchld  input  1  conditional-branch load: PC <= wr_data.
- loopen  input  1  execute LOOP.
- x  output  DATA_W  read port X.
- y  output  DATA_W  read port Y.
- pc  output  DATA_W  current PC register value.
- loop_taken  output  1  registered; 1 when the last LOOP branched.
- sreg  output  SEL_W  current source latch (debug).
- dreg  output  SEL_W  current destination latch (debug).

Behaviour:
- Reset (reset==0, asynchronous): all registers 0, sreg=0, dreg=0, loop_taken=0. Outputs follow immediately; x and y read register 0.
- Prefix latches, updated each edge:
  - with > (to, from) > resflags.
  - to and from together: each latch loads instr.
  - A prefix in the same cycle as resflags: the prefix wins.
- Read ports:
  - x = R[ssel ? instr : sreg]; y = R[ha].
  - Both are combinational reads of the registered array, zero latency.
- Write port:
  - Write address wa = dsel ? instr : dreg.
  - wr_lo updates bits [DATA_W/2-1:0]; wr_hi updates the upper half. Both set = full word.
  - The written value is visible on x/y the next cycle.
- PC register, update priority (highest first):
  1. Explicit write with wa==PC_IDX (byte lanes honoured).
  2. cchld: PC <= wr_data.
  3. loopen branch: PC <= R[LOOP_TGT_IDX].
  4. pcen: PC <= PC+1, wraps from all-ones to 0.
  5. Otherwise hold.
- LOOP (loopen=1):
  - R[LOOP_CNT_IDX] <= R[LOOP_CNT_IDX]-1 (modulo 2^DATA_W).
  - Branch when the decremented value != 0; loop_taken <= that result.
  - Not branching: PC falls through to pcen if asserted.
  - An explicit write to LOOP_CNT_IDX in the same cycle overrides the decrement, and the branch decision still uses the decremented value.
  - loopen=0: loop_taken <= 0.
- Counter wrap: a counter value of 0 decrements to all-ones, so the loop is taken.
- Reset mid-LOOP: all state cleared; no partial update is retained.
- Out-of-range indices: none; SEL_W covers NUM_REGS exactly.

Optional Feature:
GSU_RF_BYPASS_EN
- Defined: when a write hits the address being read, x and y return the merged new value in the same cycle (byte lanes honoured). A PC read through x/y sees the write-port value only, not the pcen/loop update.
- Undefined: x and y return the pre-edge register contents. This is the default and matches the GSU timing.

Decomposition:
- Package gsu_rf_pkg holds:
  - default index localparams (PC_IDX, LOOP_CNT_IDX, LOOP_TGT_IDX);
  - a write-priority enum (WR_EXPLICIT, WR_CCHLD, WR_LOOP, WR_PCINC, WR_HOLD);
  - the byte-lane merge function.
- One natural sub-module, gsu_rf_selreg: owns sreg/dreg latch state and the address muxes, and outputs the X address and write address.

Test Plan:
- Reset, then with=1 and instr=5; next cycle resflags=1, ssel=0 -> sreg=dreg=5 after the first edge; 0 after the second; x reads R0=0.
- Write R3=0xA5C3 with wr_lo only (R3 was 0x1111) -> R3=0x11C3. Then wr_hi with wr_data 0xBEEF -> R3=0xBEC3.
- PC=0xFFFF, pcen=1 -> pc=0x0000. Same cycle with cchld=1 and wr_data=0x0200 -> pc=0x0200 (cchld beats pcen).
- R12=3, R13=0x0100, pcen=1, loopen pulsed three times:
  - R12 goes 2, 1, 0.
  - loop_taken goes 1, 1, 0.
  - PC reads 0x0100, 0x0100, then 0x0101.
- dsel=1, instr=15, wr_lo=wr_hi=1 with wr_data=0x4000, plus pcen and cchld=1 -> pc=0x4000 (explicit write wins).
- GSU_RF_BYPASS_EN defined: write R7=0x1234 with ha=7 -> y=0x1234 in the same cycle. Undefined -> y shows the old value until the next cycle.
